// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: NM masters share one slave, grant locked per cyc,
// with a watchdog that answers a silent slave with err and then cuts the cycle.
module wb_rr_arbiter #(
  parameter int NM      = 3,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic [NM*32-1:0]  wbm_adr_i,
  input  logic [NM*32-1:0]  wbm_dat_i,
  input  logic [NM*4-1:0]   wbm_sel_i,
  input  logic [NM-1:0]     wbm_we_i,
  input  logic [NM-1:0]     wbm_cyc_i,
  input  logic [NM-1:0]     wbm_stb_i,
  output logic [31:0]       wbm_rdt_o,
  output logic [NM-1:0]     wbm_ack_o,
  output logic [NM-1:0]     wbm_err_o,
  output logic [31:0]       wbs_adr_o,
  output logic [31:0]       wbs_dat_o,
  output logic [3:0]        wbs_sel_o,
  output logic              wbs_we_o,
  output logic              wbs_cyc_o,
  output logic              wbs_stb_o,
  input  logic [31:0]       wbs_rdt_i,
  input  logic              wbs_ack_i,
  input  logic              wbs_err_i,
  output logic [NM-1:0]     grant_o,
  output logic              timeout_o
);

  localparam int              LW          = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [LW-1:0]   LP_LAST_RST = LW'(NM - 1);
  localparam logic            LP_WDOG_EN  = (TIMEOUT > 0);
  localparam logic [TW-1:0]   LP_LIMIT    = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : {TW{1'b0}};
  localparam logic [TW-1:0]   LP_SAT      = {TW{1'b1}};
  localparam logic [NM-1:0]   LP_ONE      = {{(NM-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [NM-1:0] r_grant, w_grant_nxt;
  logic [LW-1:0] r_gidx, w_gidx_nxt;
  logic [LW-1:0] r_last, w_last_nxt;
  logic [TW-1:0] r_cnt, w_cnt_nxt;
  logic          r_abort, w_abort_nxt;
  logic [LW-1:0] w_pick;
  logic          w_found;
  logic          w_busy, w_cyc, w_stb, w_expire;

  // Gating with wb_rst_n makes the slave cycle drop in the same instant reset asserts.
  assign w_busy   = (r_state == ST_BUSY) & wb_rst_n;
  assign w_cyc    = w_busy & wbm_cyc_i[r_gidx] & ~r_abort;
  assign w_stb    = w_cyc & wbm_stb_i[r_gidx];
  assign w_expire = LP_WDOG_EN & w_stb & ~wbs_ack_i & ~wbs_err_i & (r_cnt == LP_LIMIT);

  // Rotating search starting just after the last served master.
  always_comb begin
    w_pick  = r_last;
    w_found = 1'b0;
    for (int i = NM; i >= 1; i--) begin
      int idx;
      idx     = (int'(r_last) + i) % NM;
      w_pick  = wbm_cyc_i[idx] ? LW'(idx) : w_pick;
      w_found = w_found | wbm_cyc_i[idx];
    end
  end

  // Arbitration state, grant lock, abort and watchdog next-state.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_last_nxt  = r_last;
    w_abort_nxt = r_abort;
    w_cnt_nxt   = {TW{1'b0}};
    case (r_state)
      ST_IDLE: begin
        w_abort_nxt = 1'b0;
        if (w_found) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = LP_ONE << w_pick;
          w_gidx_nxt  = w_pick;
        end else begin
          w_grant_nxt = {NM{1'b0}};
        end
      end
      ST_BUSY: begin
        if (!wbm_cyc_i[r_gidx]) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_gidx;
          w_grant_nxt = {NM{1'b0}};
          w_abort_nxt = 1'b0;
        end else begin
          w_abort_nxt = r_abort | w_expire;
          if (w_stb && !wbs_ack_i && !wbs_err_i && LP_WDOG_EN) begin
            w_cnt_nxt = (r_cnt == LP_SAT) ? r_cnt : r_cnt + 1'b1;
          end else begin
            w_cnt_nxt = {TW{1'b0}};
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = {NM{1'b0}};
        w_abort_nxt = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= {NM{1'b0}};
      r_gidx  <= {LW{1'b0}};
      r_last  <= LP_LAST_RST;
      r_cnt   <= {TW{1'b0}};
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  // Slave-side mux from the granted master and per-master response steering.
  always_comb begin
    wbs_adr_o = 32'h0;
    wbs_dat_o = 32'h0;
    wbs_sel_o = 4'h0;
    wbs_we_o  = 1'b0;
    wbm_ack_o = {NM{1'b0}};
    wbm_err_o = {NM{1'b0}};
    if (w_busy) begin
      wbs_adr_o = wbm_adr_i[int'(r_gidx)*32 +: 32];
      wbs_dat_o = wbm_dat_i[int'(r_gidx)*32 +: 32];
      wbs_sel_o = wbm_sel_i[int'(r_gidx)*4 +: 4];
      wbs_we_o  = wbm_we_i[r_gidx];
      wbm_ack_o[r_gidx] = wbs_ack_i & w_cyc;
      wbm_err_o[r_gidx] = (wbs_err_i & w_cyc) | w_expire;
    end else begin
      wbs_we_o = 1'b0;
    end
  end

  assign wbs_cyc_o = w_cyc;
  assign wbs_stb_o = w_stb;
  assign wbm_rdt_o = wbs_rdt_i;
  assign grant_o   = r_grant;
  assign timeout_o = w_expire;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (NM=3, TIMEOUT=8): rotation, grant lock, watchdog, reset.
module tb_wb_rr_arbiter;
  localparam int NM = 3;

  logic              wb_clk = 1'b0;
  logic              wb_rst_n;
  logic [NM*32-1:0]  wbm_adr_i, wbm_dat_i;
  logic [NM*4-1:0]   wbm_sel_i;
  logic [NM-1:0]     wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [31:0]       wbm_rdt_o;
  logic [NM-1:0]     wbm_ack_o, wbm_err_o;
  logic [31:0]       wbs_adr_o, wbs_dat_o;
  logic [3:0]        wbs_sel_o;
  logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [31:0]       wbs_rdt_i;
  logic              wbs_ack_i, wbs_err_i;
  logic [NM-1:0]     grant_o;
  logic              timeout_o;

  int n_cmp = 0;
  int n_err = 0;
  int exp_g;

  wb_rr_arbiter #(.NM(NM), .TIMEOUT(8), .TW(8)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_rdt_o(wbm_rdt_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_rdt_i(wbs_rdt_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic tick();
    @(posedge wb_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr);
    wbm_cyc_i[k] = cyc;
    wbm_stb_i[k] = stb;
    wbm_we_i[k]  = we;
    wbm_adr_i[32*k +: 32] = adr;
  endtask

  initial begin
    wb_rst_n  = 1'b0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0;
    wbm_we_i  = '0; wbm_cyc_i = '0; wbm_stb_i = '0;
    wbs_rdt_i = 32'h0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0;
    repeat (3) tick();
    wb_rst_n = 1'b1;
    #1;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_cyc", 32'(wbs_cyc_o), 32'h0);
    chk("rst_ack_err", 32'({wbm_ack_o, wbm_err_o, timeout_o}), 32'h0);

    // Master 1 read, slave acks 2 cycles after stb.
    tick();
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0040);
    #1 chk("t1_cyc_idle", 32'(wbs_cyc_o), 32'h0);
    tick(); #1;
    chk("t1_cyc_up", 32'(wbs_cyc_o), 32'h1);
    chk("t1_adr", wbs_adr_o, 32'h0000_0040);
    chk("t1_grant", 32'(grant_o), 32'h2);
    tick(); #1;
    chk("t1_noack", 32'(wbm_ack_o), 32'h0);
    tick();
    wbs_ack_i = 1'b1; wbs_rdt_i = 32'hDEAD_BEEF;
    #1;
    chk("t1_ack", 32'(wbm_ack_o), 32'h2);
    chk("t1_rdt", wbm_rdt_o, 32'hDEAD_BEEF);
    tick();
    wbs_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    #1 chk("t1_grant_hold", 32'(grant_o), 32'h2);
    tick(); #1;
    chk("t1_grant_clr", 32'(grant_o), 32'h0);

    // All masters requesting: rotation after last=1, one idle cycle between grants.
    exp_g = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int m = 0; m < NM; m++) set_m(m, 1'b1, 1'b1, 1'b0, 32'h1000 + 32'(m));
      wbs_ack_i = 1'b0;
      #1 chk("t2_idle_gap", 32'(grant_o), 32'h0);
      tick();
      exp_g = (exp_g + 1) % NM;
      wbs_ack_i = 1'b1;
      #1;
      chk("t2_grant", 32'(grant_o), 32'(1) << exp_g);
      chk("t2_ack", 32'(wbm_ack_o), 32'(1) << exp_g);
      tick();
      wbs_ack_i = 1'b0;
      set_m(exp_g, 1'b0, 1'b0, 1'b0, 32'h0);
      #1 chk("t2_drop", 32'(wbs_cyc_o), 32'h0);
    end
    tick();
    for (int m = 0; m < NM; m++) set_m(m, 1'b0, 1'b0, 1'b0, 32'h0);

    // Master 0 locks the bus over 4 writes while master 2 waits.
    tick();
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h100);
    wbm_dat_i[31:0] = 32'h1111_0000; wbm_sel_i[3:0] = 4'hF;
    tick();
    set_m(2, 1'b1, 1'b1, 1'b0, 32'h200);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) tick();
      set_m(0, 1'b1, 1'b1, 1'b1, 32'h100 + 32'(4 * b));
      wbs_ack_i = 1'b1;
      #1;
      chk("t3_grant", 32'(grant_o), 32'h1);
      chk("t3_ack", 32'(wbm_ack_o), 32'h1);
      chk("t3_adr", wbs_adr_o, 32'h100 + 32'(4 * b));
      chk("t3_we_sel", 32'({wbs_we_o, wbs_sel_o}), 32'h1F);
    end
    tick();
    wbs_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1 chk("t3_m0_drop", 32'(grant_o), 32'h1);
    tick(); #1;
    chk("t3_gap", 32'(grant_o), 32'h0);
    tick(); #1;
    chk("t3_m2_grant", 32'(grant_o), 32'h4);
    wbs_ack_i = 1'b1;
    #1 chk("t3_m2_ack", 32'(wbm_ack_o), 32'h4);
    tick();
    wbs_ack_i = 1'b0;
    set_m(2, 1'b0, 1'b0, 1'b0, 32'h0);

    // Watchdog: master 2 never acked.
    tick();
    set_m(2, 1'b1, 1'b1, 1'b0, 32'h300);
    for (int k = 1; k <= 7; k++) begin
      tick(); #1;
      chk("t4_wait_err", 32'({wbm_err_o, timeout_o}), 32'h0);
      chk("t4_wait_cyc", 32'(wbs_cyc_o), 32'h1);
    end
    tick(); #1;
    chk("t4_err", 32'(wbm_err_o), 32'h4);
    chk("t4_timeout", 32'(timeout_o), 32'h1);
    tick();
    wbs_ack_i = 1'b1;
    #1;
    chk("t4_abort_cyc", 32'({wbs_cyc_o, wbs_stb_o}), 32'h0);
    chk("t4_abort_resp", 32'({wbm_ack_o, wbm_err_o, timeout_o}), 32'h0);
    chk("t4_abort_grant", 32'(grant_o), 32'h4);
    tick();
    wbs_ack_i = 1'b0;
    set_m(2, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick(); #1;
    chk("t4_m0_grant", 32'(grant_o), 32'h1);
    chk("t4_m0_cyc", 32'(wbs_cyc_o), 32'h1);
    wbs_ack_i = 1'b1;
    tick();
    wbs_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Ack on the expiry cycle wins; then a slave err with zero data.
    tick();
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h500);
    repeat (7) tick();
    tick();
    wbs_ack_i = 1'b1; wbs_rdt_i = 32'h1234_5678;
    #1;
    chk("t5_ack_win", 32'(wbm_ack_o), 32'h2);
    chk("t5_no_err", 32'({wbm_err_o, timeout_o}), 32'h0);
    tick();
    wbs_ack_i = 1'b0;
    #1 chk("t5_no_abort", 32'(wbs_cyc_o), 32'h1);
    tick();
    wbs_err_i = 1'b1; wbs_rdt_i = 32'h0;
    #1;
    chk("t5_slv_err", 32'(wbm_err_o), 32'h2);
    chk("t5_slv_err_ack", 32'(wbm_ack_o), 32'h0);
    chk("t5_rdt0", wbm_rdt_o, 32'h0);
    tick();
    wbs_err_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset mid-transfer with master 1 granted.
    tick();
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h600);
    tick(); #1;
    chk("t6_pre_cyc", 32'(wbs_cyc_o), 32'h1);
    wbs_ack_i = 1'b1;
    #1 wb_rst_n = 1'b0;
    #1;
    chk("t6_rst_cyc", 32'({wbs_cyc_o, wbs_stb_o}), 32'h0);
    chk("t6_rst_ack", 32'({wbm_ack_o, wbm_err_o}), 32'h0);
    chk("t6_rst_grant", 32'(grant_o), 32'h0);
    wbs_ack_i = 1'b0;
    tick();
    wb_rst_n = 1'b1;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h700);
    #1 chk("t6_rel_idle", 32'(grant_o), 32'h0);
    tick(); #1;
    chk("t6_m0_first", 32'(grant_o), 32'h1);
    chk("t6_m0_adr", wbs_adr_o, 32'h700);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
